alu_register: RTL and testbench
===============================

# alu_register

Sequential execution stage wrapped around the 4-bit lab ALU function set. It latches an operand and function code on a start request, executes the operation, and writes the 8-bit result into a result register. The low nibble of that register feeds back as the B operand of the next operation. It sits between the switch/key input logic and the HEX/LEDR display path, turning the combinational ALU into an accumulator-style datapath with a multi-cycle multiply.

## Interface
Parameters:
- none (widths fixed: 4-bit operands, 8-bit result)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  operation request, sampled on rising edge
- data  in  4  operand A
- func  in  3  function select
- busy  out  1  high while an accepted operation is executing
- done  out  1  one-cycle pulse after result is written
- result  out  8  result register; result[3:0] is operand B for the next op
- ops_count  out  8  completed-operation counter, wraps

## Operation
- Reset: result=0, ops_count=0, busy=0, done=0, state=IDLE, internal operand/product registers=0.
- States:
  - IDLE: not busy. On start=1, latch A=data, F=func, B=result[3:0]. Go to EXEC if F!=111, else MUL with iteration count 0.
  - EXEC: compute the F function, write result, go to IDLE.
  - MUL: one shift-add step per cycle over B bits 0..3: if B[i], product += A<<i. After the 4th step, write product to result and go to IDLE.
- Functions; all 8-bit with operands zero-extended and arithmetic mod 256:
  - 000: A+1, 5-bit sum incl. carry.
  - 001: A+B, 5-bit sum incl. carry.
  - 010: A−B, 8-bit two's complement.
  - 011: {A|B, A^B}.
  - 100: {7'b0, |{A,B}}.
  - 101: {4'b0,B} << A; any A≥8 gives 0.
  - 110: {A,B} logical >> 1.
  - 111: A×B, 8-bit unsigned, multi-cycle.
- Operands come from the latch only. Changes on data/func after acceptance have no effect.
- result changes only on the completion edge. During MUL it holds the previous value.
- ops_count increments by 1 on every completion edge (255→0). An aborted op does not count.
- start while busy=1 is ignored, not queued.

## Timing
- Start accepted at edge k; busy=1 from after edge k until the completion edge.
- Single-cycle ops: completion edge k+1. result and done valid after k+1; done drops after k+2.
- Multiply: steps at edges k+1..k+4; completion edge k+4; busy high for 4 cycles.
- done and busy are never both 1.
- Back-to-back: start=1 during the done cycle is accepted at that edge. B is taken from the just-written result.
- reset=1 at any edge, including mid-MUL, forces the reset state at that edge. It has priority over start and completion: no write, no done, no count.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then start with func=001, data=5 → after edge k+1: result=0x05, done=1 for one cycle, ops_count=1. Repeat with data=0xF → result=0x14.
- Set result low nibble to 3 (func=101, data=0: {4'b0,B}<<0 loads 0x00, then func=000 data=2 → result=0x03). Then func=111, data=0xF → busy high 4 cycles, result stays 0x03 until edge k+4, then result=0x2D, single done pulse.
- func=010, data=0 with B=1 → result=0xFF. func=000, data=0xF → result=0x10 (carry bit).
- Pulse start during the MUL busy window with a different func → ignored: the product completes with the original operands and ops_count increments by exactly 1.
- Assert reset at the 2nd MUL step → next cycle result=0, busy=0, done=0, ops_count=0; no completion occurs afterwards.
- 256 back-to-back func=011 ops with start held high → one completion every 2 cycles, ops_count wraps to 0, done never overlaps busy.

Source files
------------

// File: rtl/alu_register.sv
// alu_register: accumulator-style ALU stage with a four-cycle shift-add multiply
module alu_register (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [3:0] i_data,
    input  logic [2:0] i_func,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic [7:0] o_ops_count
);
    localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2;
    logic [1:0] r_state;
    logic [3:0] r_a, r_b;
    logic [2:0] r_f;
    logic [7:0] r_prod, r_result, r_ops;
    logic [1:0] r_step;
    logic       r_done;
    logic [7:0] w_alu, w_term, w_prod;
    // Function set on the latched operands, plus the next multiply partial product
    always_comb begin
        w_term = r_b[r_step] ? ({4'b0, r_a} << r_step) : 8'd0;
        w_prod = r_prod + w_term;
        w_alu  = r_f == 3'b000 ? {4'b0, r_a} + 8'd1
               : r_f == 3'b001 ? {4'b0, r_a} + {4'b0, r_b}
               : r_f == 3'b010 ? {4'b0, r_a} - {4'b0, r_b}
               : r_f == 3'b011 ? {r_a | r_b, r_a ^ r_b}
               : r_f == 3'b100 ? {7'b0, |{r_a, r_b}}
               : r_f == 3'b101 ? (r_a[3] ? 8'd0 : {4'b0, r_b} << r_a[2:0])
               : r_f == 3'b110 ? {r_a, r_b} >> 1
               : w_prod;
    end
    // Accept in IDLE, write on completion; reset overrides everything
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_f      <= 3'd0;
            r_prod   <= 8'd0;
            r_step   <= 2'd0;
            r_result <= 8'd0;
            r_ops    <= 8'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && i_start) begin
                r_a     <= i_data;
                r_f     <= i_func;
                r_b     <= r_result[3:0];
                r_prod  <= 8'd0;
                r_step  <= 2'd0;
                r_state <= i_func == 3'b111 ? S_MUL : S_EXEC;
            end else if (r_state == S_EXEC) begin
                r_result <= w_alu;
                r_done   <= 1'b1;
                r_ops    <= r_ops + 8'd1;
                r_state  <= S_IDLE;
            end else if (r_state == S_MUL) begin
                r_prod <= w_prod;
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3) begin
                    r_result <= w_prod;
                    r_done   <= 1'b1;
                    r_ops    <= r_ops + 8'd1;
                    r_state  <= S_IDLE;
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end
    assign o_busy      = r_state != S_IDLE;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_ops_count = r_ops;
endmodule

// File: tb/tb_alu_register.sv
// tb_alu_register: directed vector table plus multiply, abort and back-to-back sequences
module tb_alu_register;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] data;
    logic [2:0] func;
    logic       busy, done;
    logic [7:0] result, ops;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [2:0] f;
        logic [3:0] d;
        logic [7:0] res;
        logic [7:0] ops;
        int         lat;
    } vec_t;
    vec_t v [16];

    alu_register dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_data(data), .i_func(func),
        .o_busy(busy), .o_done(done), .o_result(result), .o_ops_count(ops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit held, input logic [7:0] prev);
        n = 0;
        held = 1'b1;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (result !== prev) held = 1'b0;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [3:0] d, input logic [7:0] er,
                          input logic [7:0] eops, input int elat, input string tag);
        logic [7:0] prev;
        int n;
        bit held;
        @(negedge clk);
        start = 1'b1;
        func = f;
        data = d;
        prev = result;
        @(negedge clk);
        start = 1'b0;
        func = ~f;
        data = ~d;
        chk({tag, " busy after accept"}, busy, 1);
        chk({tag, " done while busy"}, done, 0);
        wait_done(n, held, prev);
        chk({tag, " latency"}, n, elat);
        chk({tag, " result"}, result, er);
        chk({tag, " ops_count"}, ops, eops);
        chk({tag, " busy with done"}, busy, 0);
        chk({tag, " result held"}, held, 1);
    endtask

    initial begin
        int n, nd, overl, gaps, last;
        bit held;
        v[0]  = '{3'b001, 4'h5, 8'h05, 8'd1, 1};
        v[1]  = '{3'b001, 4'hF, 8'h14, 8'd2, 1};
        v[2]  = '{3'b101, 4'h0, 8'h04, 8'd3, 1};
        v[3]  = '{3'b000, 4'h2, 8'h03, 8'd4, 1};
        v[4]  = '{3'b110, 4'h0, 8'h01, 8'd5, 1};
        v[5]  = '{3'b010, 4'h0, 8'hFF, 8'd6, 1};
        v[6]  = '{3'b000, 4'hF, 8'h10, 8'd7, 1};
        v[7]  = '{3'b011, 4'hA, 8'hAA, 8'd8, 1};
        v[8]  = '{3'b011, 4'h5, 8'hFF, 8'd9, 1};
        v[9]  = '{3'b100, 4'h0, 8'h01, 8'd10, 1};
        v[10] = '{3'b101, 4'h3, 8'h08, 8'd11, 1};
        v[11] = '{3'b101, 4'h8, 8'h00, 8'd12, 1};
        v[12] = '{3'b100, 4'h0, 8'h00, 8'd13, 1};
        v[13] = '{3'b110, 4'hF, 8'h78, 8'd14, 1};
        v[14] = '{3'b111, 4'h5, 8'h28, 8'd15, 4};
        v[15] = '{3'b001, 4'h9, 8'h11, 8'd16, 1};
        rst = 1'b0;
        start = 1'b0;
        data = 4'h0;
        func = 3'b000;
        do_reset();
        chk("reset result", result, 8'h00);
        chk("reset ops_count", ops, 8'd0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);

        for (int i = 0; i < 16; i++)
            run_op(v[i].f, v[i].d, v[i].res, v[i].ops, v[i].lat, $sformatf("vec%0d", i));

        do_reset();
        run_op(3'b101, 4'h0, 8'h00, 8'd1, 1, "load0");
        run_op(3'b000, 4'h2, 8'h03, 8'd2, 1, "load3");
        run_op(3'b111, 4'hF, 8'h2D, 8'd3, 4, "mul15x3");
        @(negedge clk);
        chk("mul done single pulse", done, 0);

        @(negedge clk);
        start = 1'b1;
        func = 3'b111;
        data = 4'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        func = 3'b000;
        data = 4'h7;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, held, 8'h2D);
        chk("ignored start latency", n, 2);
        chk("ignored start result", result, 8'h1A);
        chk("ignored start ops_count", ops, 8'd4);
        chk("ignored start held", held, 1);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("no queued op", nd, 0);
        chk("ops after ignore", ops, 8'd4);

        do_reset();
        run_op(3'b000, 4'h4, 8'h05, 8'd1, 1, "preabort");
        @(negedge clk);
        start = 1'b1;
        func = 3'b111;
        data = 4'h3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort result", result, 8'h00);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort ops_count", ops, 8'd0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy || result != 8'h00) nd++;
        end
        chk("no completion after abort", nd, 0);

        @(negedge clk);
        start = 1'b1;
        func = 3'b011;
        data = 4'h3;
        nd = 0;
        overl = 0;
        gaps = 0;
        last = -1;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            if (done && busy) overl++;
            if (done) begin
                nd++;
                if (last >= 0 && i - last != 2) gaps++;
                last = i;
            end
        end
        start = 1'b0;
        chk("b2b completions", nd, 256);
        chk("b2b done/busy overlap", overl, 0);
        chk("b2b spacing", gaps, 0);
        chk("b2b ops_count wrap", ops, 8'd0);
        chk("b2b final result", result, 8'h30);
        chk("b2b last done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
